// File: rtl/vga_scan_driver_pkg.sv
// Purpose : shared timing defaults, derived totals and the colour struct for the VGA scan driver.
// Latency : n/a (constants, types and one pure helper function).
// Flow    : n/a. Ports: none (package).
package vga_pkg;

  // Default 640x480@60 Hz timing from a 50 MHz system clock (2 clk per pixel).
  localparam int DEF_CLK_DIV  = 2;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;

  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Derived totals and sync windows (inclusive bounds) for the default timing.
  localparam int H_TOTAL      = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;  // 800
  localparam int V_TOTAL      = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;  // 525
  localparam int H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;                          // 656
  localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SYNC - 1;                    // 751
  localparam int V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;                          // 490
  localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SYNC - 1;                    // 491

  // One pixel of colour as presented to / by the DAC.
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // True when a 10-bit counter value lies in the inclusive window [lo, hi].
  function automatic logic in_window(input logic [9:0] v,
                                     input logic [9:0] lo,
                                     input logic [9:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_scan_driver_pix_strobe.sv
// Purpose : system-clock divider producing the pixel strobe and the DAC pixel clock.
// Latency : pix_en is combinational from the divider; vga_clk is registered and tracks the divider phase.
// Flow    : free-running, no backpressure.
// Ports   : clk, reset (sync, active-high) -> pix_en (1 clk per pixel), vga_clk (DAC clock).
module vga_pix_strobe #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  output logic pix_en,
  output logic vga_clk
);

  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

  logic [DW-1:0] div;
  logic [DW-1:0] div_nxt;

  always_comb begin
    pix_en  = (div == DIV_LAST);
    div_nxt = pix_en ? '0 : div + 1'b1;
  end

  // vga_clk is computed from the next divider value so that the registered
  // clock equals (div >= CLK_DIV/2) in the same cycle. Its rising edge thus
  // lands mid-pixel, half a pixel after the DAC data changed on pix_en.
  always_ff @(posedge clk) begin
    if (reset) begin
      div     <= '0;
      vga_clk <= 1'b0;
    end else begin
      div     <= div_nxt;
      vga_clk <= (div_nxt >= DIV_HALF);
    end
  end

endmodule

// File: rtl/vga_scan_driver.sv
// Purpose : VGA raster generator; presents (x, y) to the colour module and drives aligned DAC pins.
// Latency : x/y load with hc/vc; colour is expected 1 clk later; DAC pins update on the next pixel strobe.
// Flow    : free-running scan, no backpressure; r/g/b must be valid 1 clk after x/y change.
// Ports   : clk, reset (sync, active-high), r_in/g_in/b_in (colour for the previous x/y) ->
//           x, y, frame_start, VGA_R/G/B, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK.
module vga_scan_driver
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] r_in,
  input  logic [7:0] g_in,
  input  logic [7:0] b_in,
  output logic [9:0] x,
  output logic [8:0] y,
  output logic       frame_start,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic       VGA_CLK
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_ACT_C    = 10'(H_ACTIVE);
  localparam logic [9:0] H_LAST_C   = 10'(H_TOT - 1);
  localparam logic [9:0] HS_START_C = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END_C   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);

  localparam logic [9:0] V_ACT_C    = 10'(V_ACTIVE);
  localparam logic [9:0] V_LAST_C   = 10'(V_TOT - 1);
  localparam logic [9:0] VS_START_C = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END_C   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic       pix_en;

  logic [9:0] hc;
  logic [9:0] vc;
  logic [9:0] hc_nxt;
  logic [9:0] vc_nxt;
  logic       h_wrap;
  logic       v_last;
  logic       nxt_active;

  logic       act_raw;
  logic       hs_raw_n;
  logic       vs_raw_n;

  rgb_t       colour_in;
  rgb_t       dac_rgb;

  vga_pix_strobe #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_strobe (
    .clk     (clk),
    .reset   (reset),
    .pix_en  (pix_en),
    .vga_clk (VGA_CLK)
  );

  // Next scan position; vc only moves when the line wraps.
  always_comb begin
    h_wrap     = (hc == H_LAST_C);
    v_last     = (vc == V_LAST_C);
    hc_nxt     = h_wrap ? 10'd0 : hc + 10'd1;
    vc_nxt     = vc;
    if (h_wrap) begin
      vc_nxt = v_last ? 10'd0 : vc + 10'd1;
    end
    nxt_active = (hc_nxt < H_ACT_C) && (vc_nxt < V_ACT_C);
  end

  // Raw timing of the pixel currently held in hc/vc. Its colour is what
  // r_in/g_in/b_in carry by the next strobe, so loading the DAC from these
  // raw values on that strobe delays sync/blank by exactly one pixel and
  // keeps them aligned with the colour.
  always_comb begin
    act_raw   = (hc < H_ACT_C) && (vc < V_ACT_C);
    hs_raw_n  = ~in_window(hc, HS_START_C, HS_END_C);
    vs_raw_n  = ~in_window(vc, VS_START_C, VS_END_C);
    colour_in = '{r: r_in, g: g_in, b: b_in};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hc          <= 10'd0;
      vc          <= 10'd0;
      x           <= 10'd0;
      y           <= 9'd0;
      frame_start <= 1'b0;
      dac_rgb     <= '0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (pix_en) begin
        hc <= hc_nxt;
        vc <= vc_nxt;
        // x/y follow the position being loaded so the colour module sees the
        // new pixel one clock before the DAC needs its colour.
        x  <= nxt_active ? hc_nxt : 10'd0;
        y  <= nxt_active ? vc_nxt[8:0] : 9'd0;
        // Only a natural wrap to (0,0) pulses; a reset restart does not.
        frame_start <= h_wrap && v_last;

        dac_rgb     <= act_raw ? colour_in : '0;
        VGA_HS      <= hs_raw_n;
        VGA_VS      <= vs_raw_n;
        VGA_BLANK_N <= act_raw;
      end
    end
  end

  assign VGA_R      = dac_rgb.r;
  assign VGA_G      = dac_rgb.g;
  assign VGA_B      = dac_rgb.b;
  assign VGA_SYNC_N = 1'b0;

endmodule
